// File: rtl/rca_result_checker.sv
// Self-checking monitor for a ripple-carry adder: predicts {cout, s}, aligns it to the adder
// latency, compares, counts and captures the first failure. Optional coverage: RCA_CHK_COVER_EN.
module rca_result_checker #(
    parameter int WIDTH       = 4,
    parameter int LATENCY     = 0,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [WIDTH-1:0] res_s,
    input  logic             res_cout,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic             halted,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic             first_ci,
    output logic [WIDTH:0]   first_got,
    output logic [WIDTH:0]   first_exp
`ifdef RCA_CHK_COVER_EN
    ,
    output logic [CNT_W-1:0] cout_hits,
    output logic [CNT_W-1:0] max_hits
`endif
);

    localparam int EW = WIDTH + 1;

    typedef enum logic {CHECK, HALT} state_t;
    state_t state;

    logic [EW-1:0]    in_exp;
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_ci;
    logic [EW-1:0]    cmp_exp;
    logic [EW-1:0]    got;
    logic             do_cmp;
    logic             mismatch;

    assign in_exp = {1'b0, in_a} + {1'b0, in_b} + EW'(in_ci);

    generate
        if (LATENCY == 0) begin : g_nodly
            assign cmp_valid = in_valid;
            assign cmp_a     = in_a;
            assign cmp_b     = in_b;
            assign cmp_ci    = in_ci;
            assign cmp_exp   = in_exp;
        end else begin : g_dly
            logic [LATENCY-1:0] dv;
            logic [WIDTH-1:0]   da [LATENCY];
            logic [WIDTH-1:0]   db [LATENCY];
            logic               dci[LATENCY];
            logic [EW-1:0]      de [LATENCY];

            // Only the valid bits need clearing; payload is don't-care while invalid.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    dv <= '0;
                end else begin
                    dv[0] <= in_valid;
                    for (int i = 1; i < LATENCY; i++) dv[i] <= dv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                da[0]  <= in_a;
                db[0]  <= in_b;
                dci[0] <= in_ci;
                de[0]  <= in_exp;
                for (int i = 1; i < LATENCY; i++) begin
                    da[i]  <= da[i-1];
                    db[i]  <= db[i-1];
                    dci[i] <= dci[i-1];
                    de[i]  <= de[i-1];
                end
            end

            assign cmp_valid = dv[LATENCY-1];
            assign cmp_a     = da[LATENCY-1];
            assign cmp_b     = db[LATENCY-1];
            assign cmp_ci    = dci[LATENCY-1];
            assign cmp_exp   = de[LATENCY-1];
        end
    endgenerate

    assign got      = {res_cout, res_s};
    assign do_cmp   = cmp_valid && (state == CHECK);
    assign mismatch = (got != cmp_exp);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= CHECK;
            chk_count  <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
            halted     <= 1'b0;
            first_a    <= '0;
            first_b    <= '0;
            first_ci   <= 1'b0;
            first_got  <= '0;
            first_exp  <= '0;
`ifdef RCA_CHK_COVER_EN
            cout_hits  <= '0;
            max_hits   <= '0;
`endif
        end else if (do_cmp) begin
            chk_count <= sat_inc(chk_count);
            if (mismatch) begin
                err_count <= sat_inc(err_count);
                if (!err_sticky) begin
                    err_sticky <= 1'b1;
                    first_a    <= cmp_a;
                    first_b    <= cmp_b;
                    first_ci   <= cmp_ci;
                    first_got  <= got;
                    first_exp  <= cmp_exp;
                end
                if (STOP_ON_ERR != 0) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            end
`ifdef RCA_CHK_COVER_EN
            if (cmp_exp[EW-1]) cout_hits <= sat_inc(cout_hits);
            if ((&cmp_a) && (&cmp_b)) max_hits <= sat_inc(max_hits);
`endif
        end
    end

endmodule

// File: tb/tb_rca_result_checker.sv
// Randomized + directed bench for rca_result_checker: one zero-latency instance and one
// two-cycle, 4-bit-counter, stop-on-error instance, checked against a vector-history model.
module tb_rca_result_checker;

    localparam int HN = 2048;

    logic clk = 1'b0;
    logic rst, clr, in_valid, in_ci;
    logic [3:0] in_a, in_b;
    logic [3:0] res_s0, res_s1;
    logic res_c0, res_c1;

    logic [15:0] chk0, err0;
    logic [3:0]  chk1, err1;
    logic sticky0, sticky1, halted0, halted1, fci0, fci1;
    logic [3:0] fa0, fb0, fa1, fb1;
    logic [4:0] fg0, fe0, fg1, fe1;
`ifdef RCA_CHK_COVER_EN
    logic [15:0] couth0, maxh0;
    logic [3:0]  couth1, maxh1;
`endif

    always #5 clk = ~clk;

    rca_result_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(16), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ci(in_ci), .res_s(res_s0), .res_cout(res_c0), .chk_count(chk0), .err_count(err0),
        .err_sticky(sticky0), .halted(halted0), .first_a(fa0), .first_b(fb0), .first_ci(fci0),
        .first_got(fg0), .first_exp(fe0)
`ifdef RCA_CHK_COVER_EN
        , .cout_hits(couth0), .max_hits(maxh0)
`endif
    );

    rca_result_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(4), .STOP_ON_ERR(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ci(in_ci), .res_s(res_s1), .res_cout(res_c1), .chk_count(chk1), .err_count(err1),
        .err_sticky(sticky1), .halted(halted1), .first_a(fa1), .first_b(fb1), .first_ci(fci1),
        .first_got(fg1), .first_exp(fe1)
`ifdef RCA_CHK_COVER_EN
        , .cout_hits(couth1), .max_hits(maxh1)
`endif
    );

    int lat  [2] = '{0, 2};
    int cmax [2] = '{65535, 15};
    int stop [2] = '{0, 1};

    // History of every presented vector, indexed by cycle; a vector is dropped if a clear
    // happened at or after its issue cycle.
    int h_v[HN], h_a[HN], h_b[HN], h_ci[HN], h_got[HN];
    int cyc      = 0;
    int last_clr = -1;

    int m_chk[2], m_err[2], m_sticky[2], m_halt[2];
    int m_fa[2], m_fb[2], m_fci[2], m_fg[2], m_fe[2], m_cov[2], m_max[2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int inc_sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_chk[i] = 0; m_err[i] = 0; m_sticky[i] = 0; m_halt[i] = 0;
            m_fa[i] = 0; m_fb[i] = 0; m_fci[i] = 0; m_fg[i] = 0; m_fe[i] = 0;
            m_cov[i] = 0; m_max[i] = 0;
        end
    endtask

    task automatic compare_all();
        check("d0.chk", chk0, m_chk[0]);      check("d1.chk", chk1, m_chk[1]);
        check("d0.err", err0, m_err[0]);      check("d1.err", err1, m_err[1]);
        check("d0.sticky", sticky0, m_sticky[0]); check("d1.sticky", sticky1, m_sticky[1]);
        check("d0.halted", halted0, m_halt[0]);   check("d1.halted", halted1, m_halt[1]);
        check("d0.first_a", fa0, m_fa[0]);    check("d1.first_a", fa1, m_fa[1]);
        check("d0.first_b", fb0, m_fb[0]);    check("d1.first_b", fb1, m_fb[1]);
        check("d0.first_ci", fci0, m_fci[0]); check("d1.first_ci", fci1, m_fci[1]);
        check("d0.first_got", fg0, m_fg[0]);  check("d1.first_got", fg1, m_fg[1]);
        check("d0.first_exp", fe0, m_fe[0]);  check("d1.first_exp", fe1, m_fe[1]);
`ifdef RCA_CHK_COVER_EN
        check("d0.cout_hits", couth0, m_cov[0]); check("d1.cout_hits", couth1, m_cov[1]);
        check("d0.max_hits", maxh0, m_max[0]);   check("d1.max_hits", maxh1, m_max[1]);
`endif
    endtask

    // One clock cycle: present inputs, let the fake adders answer, advance the model, check.
    task automatic step(input bit r, input bit c, input bit v,
                        input int a, input int b, input int ci, input bit bad);
        int sum, src, rv, e;
        if (cyc >= HN) begin
            $display("FAIL history: cycle budget %0d exceeded", HN);
            $fatal(1, "history overflow");
        end
        sum = a + b + ci;
        h_v[cyc] = v; h_a[cyc] = a; h_b[cyc] = b; h_ci[cyc] = ci;
        h_got[cyc] = bad ? (sum ^ 17) : sum;
        rst = r; clr = c; in_valid = v;
        in_a = 4'(a); in_b = 4'(b); in_ci = 1'(ci);

        src = cyc - lat[0];
        rv  = (src >= 0) ? h_got[src] : 0;
        {res_c0, res_s0} = 5'(rv);
        src = cyc - lat[1];
        rv  = (src >= 0) ? h_got[src] : 0;
        {res_c1, res_s1} = 5'(rv);

        if (r || c) begin
            model_clear();
            last_clr = cyc;
        end else begin
            for (int i = 0; i < 2; i++) begin
                src = cyc - lat[i];
                if (src >= 0 && src > last_clr && h_v[src] != 0 && m_halt[i] == 0) begin
                    e = h_a[src] + h_b[src] + h_ci[src];
                    m_chk[i] = inc_sat(m_chk[i], cmax[i]);
                    if (e >= 16) m_cov[i] = inc_sat(m_cov[i], cmax[i]);
                    if (h_a[src] == 15 && h_b[src] == 15) m_max[i] = inc_sat(m_max[i], cmax[i]);
                    if (h_got[src] != e) begin
                        m_err[i] = inc_sat(m_err[i], cmax[i]);
                        if (m_sticky[i] == 0) begin
                            m_sticky[i] = 1;
                            m_fa[i] = h_a[src]; m_fb[i] = h_b[src]; m_fci[i] = h_ci[src];
                            m_fg[i] = h_got[src]; m_fe[i] = e;
                        end
                        if (stop[i] != 0) m_halt[i] = 1;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst.chk0", chk0, 0);
        check("rst.halted1", halted1, 0);
        check("rst.first_exp0", fe0, 0);

        // Single good vector, then a first and a second bad vector.
        step(0, 0, 1, 3, 5, 0, 0);
        check("tp.good_chk0", chk0, 1);
        check("tp.good_err0", err0, 0);
        check("tp.good_sticky0", sticky0, 0);
        step(0, 0, 1, 8, 8, 1, 1);
        check("tp.bad_err0", err0, 1);
        check("tp.bad_sticky0", sticky0, 1);
        check("tp.bad_first_got0", fg0, 5'b00000);
        check("tp.bad_first_exp0", fe0, 5'b10001);
        step(0, 0, 1, 2, 7, 0, 1);
        check("tp.bad2_err0", err0, 2);
        check("tp.bad2_first_a0", fa0, 8);
        idle(3);
        check("tp.halt_d1", halted1, 1);

        // Back-to-back vectors through the two-cycle instance.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k <= 8; k++) step(0, 0, 1, k, k, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("tp.lat_chk1_early", chk1, 8);
        step(0, 0, 0, 0, 0, 0, 0);
        check("tp.lat_chk1", chk1, 9);
        check("tp.lat_err1", err1, 0);

        // Saturation, then clear colliding with a compare.
        for (int k = 0; k < 20; k++) step(0, 0, 1, k % 16, (k * 3) % 16, k % 2, 0);
        idle(2);
        check("tp.sat_chk1", chk1, 15);
        step(0, 1, 1, 4, 4, 0, 0);
        check("tp.clr_chk0", chk0, 0);
        check("tp.clr_chk1", chk1, 0);

        // Stop-on-error: one bad vector then five good ones.
        step(0, 0, 1, 9, 3, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1, k, 1, 0, 0);
        idle(2);
        check("tp.stop_halted1", halted1, 1);
        check("tp.stop_chk1", chk1, 1);
        check("tp.stop_err1", err1, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("tp.stop_clr_halted1", halted1, 0);
        step(0, 0, 1, 6, 2, 0, 0);
        idle(2);
        check("tp.stop_next_chk1", chk1, 1);

        // Coverage vectors.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 15, 15, 1, 0);
        step(0, 0, 1, 1, 2, 0, 0);
        check("tp.cov_chk0", chk0, 2);
`ifdef RCA_CHK_COVER_EN
        check("tp.cov_cout0", couth0, 1);
        check("tp.cov_max0", maxh0, 1);
`endif

        // Randomized traffic with occasional clear and reset mid-stream.
        for (int k = 0; k < 400; k++) begin
            bit r, c, v, bad;
            int a, b;
            r   = ($urandom_range(99) == 0);
            c   = ($urandom_range(29) == 0);
            v   = ($urandom_range(3) != 0);
            bad = ($urandom_range(9) == 0);
            a   = ($urandom_range(5) == 0) ? 15 : int'($urandom_range(15));
            b   = ($urandom_range(5) == 0) ? 15 : int'($urandom_range(15));
            step(r, c, v, a, b, int'($urandom_range(1)), bad);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
